jt1943_inputs: RTL
==================

# jt1943_inputs

Cabinet input conditioner sitting directly upstream of `jt1943_game`. It produces that module's `start_button`, `coin_input`, `joystick1`, `joystick2` and `service` inputs from raw, bouncy, active-low cabinet lines. It provides:
- per-bit debouncing;
- frame-synchronous coin pulse shaping with a small pending-coin queue;
- the 1943 loop macro, where button 3 forces buttons 1 and 2.

## Interface
Parameters:
- `TICK_DIV`, 48000: clk cycles per debounce sample tick (1 ms at 48 MHz); 16-bit prescaler.
- `DEB_TICKS`, 4: consecutive disagreeing ticks required to flip a debounced bit (1..7).
- `COIN_FRAMES`, 4: coin pulse low width, in frames.
- `COIN_GAP`, 8: minimum high time between coin pulses, in frames.

Ports (all cabinet signals active-low):
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `LVBL`  in  1  vertical blank from the game timer; each falling edge is a frame tick.
- `start_raw`  in  2  raw start buttons.
- `coin_raw`  in  2  raw coin switches.
- `joy1_raw`  in  7  raw player 1 inputs: [3:0] directions, [6:4] buttons 1..3.
- `joy2_raw`  in  7  raw player 2 inputs, same layout.
- `service_raw`  in  1  raw service switch.
- `start_button`  out  2  debounced start buttons.
- `coin_input`  out  2  shaped coin pulses.
- `joystick1`  out  7  debounced player 1 inputs with the loop macro applied.
- `joystick2`  out  7  debounced player 2 inputs with the loop macro applied.
- `service`  out  1  debounced service switch.
- `coin_pend`  out  4  pending coin counts, {slot1, slot0}, 2 bits each.

## Operation
- Prescaler: counts 0..`TICK_DIV`-1 and issues a one-cycle `tick` at the wrap.
- Debounce: applies to each of the 19 bits (start 2, coin 2, joy 14, service 1).
  - Each bit has a 3-bit counter.
  - On `tick`: if the raw bit differs from its debounced value, the counter increments; otherwise it clears.
  - When the counter reaches `DEB_TICKS`, the debounced bit takes the raw value and the counter clears.
- Loop macro, per player: `joystickN[3:0]` and `joystickN[6]` carry the debounced values. `joystickN[5:4]` = debounced[5:4] & {2{debounced[6]}}.
- Frame tick: `LVBL_l` is registered with reset value 0. `frame` = `LVBL_l & ~LVBL`. There is no spurious tick after reset.
- Coin slot FSM, one instance per slot:
  - States: IDLE, PULSE, GAP.
  - `pend` is 2 bits. It increments, saturating at 3, on a debounced coin falling edge (1→0).
  - IDLE: when `pend`≠0, go to PULSE, decrement `pend`, load the frame counter with `COIN_FRAMES`.
  - PULSE: `coin_input`=0. Decrement the counter on `frame`; at 0, load `COIN_GAP` and go to GAP.
  - GAP: `coin_input`=1. Decrement on `frame`; at 0, go to IDLE.
  - An increment and a decrement in the same cycle leave `pend` unchanged. An increment at `pend`=3 is dropped.
  - A held coin switch counts once.
- Reset values:
  - All cabinet outputs 1 (released).
  - `coin_pend` = 0; all counters 0; FSMs in IDLE.
  - Debounced state 1 per bit.

## Timing
- All outputs are registered.
- Debounce latency: a raw change held stable is visible 1 clk after the `DEB_TICKS`-th tick following the change.
- A raw glitch shorter than `DEB_TICKS` ticks produces no output change.
- Coin pulse starts 1 clk after IDLE sees `pend`≠0.
- Coin pulse width is exactly `COIN_FRAMES` frame ticks, ending on the tick that drives the counter to 0. The pulse's first frame may be partial.
- Minimum spacing between pulses is `COIN_GAP` full frame ticks.
- Loop macro is combinational on registered debounced bits, then registered: same latency as debounce.
- `rst_n` assertion mid-pulse forces `coin_input` high immediately (asynchronous) and clears the queue.

## Structure
- Shared package: localparams for the FSM state encoding (IDLE=0, PULSE=1, GAP=2) and for the joystick bit positions (directions 0..3, buttons 4..6).
- Sub-module `jt1943_inputs_coin`: the coin slot FSM, queue and frame counter, instantiated twice.
- Prescaler, debounce array and loop macro live in the top.

## Test plan
Bench runs with `TICK_DIV`=4 and an LVBL period of 64 clk.
- Reset: hold `rst_n`=0 with raw lines toggling → all outputs 1, `coin_pend`=0. Release with `LVBL`=0 → no coin activity.
- Glitch: `joy1_raw[0]` low for 3 ticks then high → `joystick1[0]` stays 1. Held low for 4 ticks → `joystick1[0]`=0 one clk after the 4th tick.
- Loop macro: `joy2_raw[6]` low, `joy2_raw[5:4]`=11 → after debounce, `joystick2[6:4]`=000. Release → 111.
- Single coin: one 10-tick press on `coin_raw[0]` → `coin_input[0]` low for exactly 4 frame ticks, then high. `coin_pend`[1:0] returns to 0.
- Burst: 5 presses on slot 1 during the first pulse → `coin_pend`[3:2] saturates at 3. Exactly 4 pulses result, each separated by ≥8 frames. Slot 0 is unaffected.
- Reset mid-operation: assert `rst_n` during PULSE with `pend`=2 → `coin_input`=1 in the same cycle. After release, no further pulses occur.

Source files
------------

// File: rtl/jt1943_inputs_pkg.sv
// Shared definitions for the 1943 cabinet input conditioner: coin FSM states,
// joystick bit positions, debounce vector layout and the loop-macro helper.
package jt1943_inputs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_t;

    localparam int JOY_DIR0 = 0;
    localparam int JOY_DIR3 = 3;
    localparam int JOY_BUT1 = 4;
    localparam int JOY_BUT2 = 5;
    localparam int JOY_BUT3 = 6;

    // Layout of the 19-bit debounce vector
    localparam int BIT_START   = 0;
    localparam int BIT_COIN    = 2;
    localparam int BIT_JOY1    = 4;
    localparam int BIT_JOY2    = 11;
    localparam int BIT_SERVICE = 18;
    localparam int N_DEB       = 19;

    // Button 3 (active low) pulls buttons 1 and 2 low with it.
    function automatic logic [6:0] loop_macro(input logic [6:0] d);
        logic [6:0] r;
        r = d;
        r[JOY_DIR3:JOY_DIR0] = d[JOY_DIR3:JOY_DIR0];
        r[JOY_BUT1] = d[JOY_BUT1] & d[JOY_BUT3];
        r[JOY_BUT2] = d[JOY_BUT2] & d[JOY_BUT3];
        return r;
    endfunction

endpackage

// File: rtl/jt1943_inputs_coin.sv
// One coin slot: counts debounced coin insertions into a small saturating queue
// and replays them as frame-timed active-low pulses separated by a minimum gap.
module jt1943_inputs_coin
    import jt1943_inputs_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int COIN_GAP    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame,
    input  logic       coin,
    output logic       pulse_n,
    output logic [1:0] pend
);

    coin_state_t state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [1:0]  pend_reg, pend_next;
    logic        out_reg, out_next;
    logic        coin_l_reg;
    logic        fall;
    logic        inc;
    logic        dec;

    // A held switch produces a single falling edge, so it counts once.
    assign fall = coin_l_reg & ~coin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 8'd0;
            pend_reg   <= 2'd0;
            out_reg    <= 1'b1;
            coin_l_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pend_reg   <= pend_next;
            out_reg    <= out_next;
            coin_l_reg <= coin;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        dec        = 1'b0;
        inc        = fall && (pend_reg != 2'd3);
        case (state_reg)
            ST_IDLE: begin
                out_next = 1'b1;
                if (pend_reg != 2'd0) begin
                    dec        = 1'b1;
                    state_next = ST_PULSE;
                    cnt_next   = 8'(COIN_FRAMES);
                    out_next   = 1'b0;
                end
            end
            ST_PULSE: begin
                out_next = 1'b0;
                if (frame) begin
                    if (cnt_reg <= 8'd1) begin
                        cnt_next   = 8'(COIN_GAP);
                        state_next = ST_GAP;
                        out_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
            end
            ST_GAP: begin
                out_next = 1'b1;
                if (frame) begin
                    if (cnt_reg <= 8'd1) begin
                        cnt_next   = 8'd0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 8'd0;
                out_next   = 1'b1;
            end
        endcase

        // Simultaneous insert and dispatch cancel out.
        pend_next = pend_reg;
        if (inc && !dec) begin
            pend_next = pend_reg + 2'd1;
        end else if (dec && !inc) begin
            pend_next = pend_reg - 2'd1;
        end
    end

    assign pulse_n = out_reg;
    assign pend    = pend_reg;

endmodule

// File: rtl/jt1943_inputs.sv
// Cabinet input conditioner for jt1943_game: per-bit debounce on a slow tick,
// the button-3 loop macro, and two frame-synchronous coin pulse shapers.
module jt1943_inputs
    import jt1943_inputs_pkg::*;
#(
    parameter int TICK_DIV    = 48000,
    parameter int DEB_TICKS   = 4,
    parameter int COIN_FRAMES = 4,
    parameter int COIN_GAP    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LVBL,
    input  logic [1:0] start_raw,
    input  logic [1:0] coin_raw,
    input  logic [6:0] joy1_raw,
    input  logic [6:0] joy2_raw,
    input  logic       service_raw,
    output logic [1:0] start_button,
    output logic [1:0] coin_input,
    output logic [6:0] joystick1,
    output logic [6:0] joystick2,
    output logic       service,
    output logic [3:0] coin_pend
);

    localparam logic [2:0]  DEB_LAST = 3'(DEB_TICKS - 1);
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [N_DEB-1:0] raw;
    logic [N_DEB-1:0] deb_reg, deb_next;
    logic [15:0]      div_reg;
    logic             tick;
    logic             lvbl_l_reg;
    logic             frame;
    logic [1:0]       start_reg;
    logic [6:0]       joy1_reg, joy2_reg;
    logic             service_reg;

    assign raw = {service_raw, joy2_raw, joy1_raw, coin_raw, start_raw};

    assign tick = (div_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= 16'd0;
        end else begin
            div_reg <= tick ? 16'd0 : div_reg + 16'd1;
        end
    end

    // The flip happens on the tick that would bring the counter to DEB_TICKS,
    // so the counter itself never needs to hold that value.
    genvar gi;
    generate
        for (gi = 0; gi < N_DEB; gi = gi + 1) begin : g_deb
            logic [2:0] cnt_reg;
            logic       differ;
            logic       flip;

            assign differ        = raw[gi] != deb_reg[gi];
            assign flip          = tick && differ && (cnt_reg == DEB_LAST);
            assign deb_next[gi]  = flip ? raw[gi] : deb_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 3'd0;
                end else if (tick) begin
                    if (differ && !flip) begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end else begin
                        cnt_reg <= 3'd0;
                    end
                end
            end
        end
    endgenerate

    // Outputs are registered from deb_next so they land with the debounced state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_reg     <= '1;
            start_reg   <= 2'b11;
            joy1_reg    <= 7'h7f;
            joy2_reg    <= 7'h7f;
            service_reg <= 1'b1;
        end else begin
            deb_reg     <= deb_next;
            start_reg   <= deb_next[BIT_START +: 2];
            joy1_reg    <= loop_macro(deb_next[BIT_JOY1 +: 7]);
            joy2_reg    <= loop_macro(deb_next[BIT_JOY2 +: 7]);
            service_reg <= deb_next[BIT_SERVICE];
        end
    end

    // Reset value 0 keeps a low LVBL at release from looking like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvbl_l_reg <= 1'b0;
        end else begin
            lvbl_l_reg <= LVBL;
        end
    end

    assign frame = lvbl_l_reg & ~LVBL;

    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_coin
            jt1943_inputs_coin #(
                .COIN_FRAMES (COIN_FRAMES),
                .COIN_GAP    (COIN_GAP)
            ) u_coin (
                .clk     (clk),
                .rst_n   (rst_n),
                .frame   (frame),
                .coin    (deb_reg[BIT_COIN + gi]),
                .pulse_n (coin_input[gi]),
                .pend    (coin_pend[2*gi +: 2])
            );
        end
    endgenerate

    assign start_button = start_reg;
    assign joystick1    = joy1_reg;
    assign joystick2    = joy2_reg;
    assign service      = service_reg;

endmodule
